universal_storage_register: RTL and testbench

Parameterised successor to the single-bit latch/flip-flop comparison block. It is a WIDTH-bit universal register with a selectable capture edge, seven operating modes, serial in/out on both ends, and a frame counter that flags every WIDTH consecutive shift/rotate operations. It is the general-purpose storage and serialisation element for the storage-elements design area.

---
 rtl/storage_pkg.sv | 32 +++
 rtl/universal_storage_register_frame_counter.sv | 67 ++++++
 rtl/universal_storage_register.sv | 120 ++++++++++++
 tb/tb_universal_storage_register.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/storage_pkg.sv
// ----------------------------------------------------------------------------
// storage_pkg
// Shared definitions for the universal storage register:
//   - mode_e     : operation select encoding
//   - cnt_width  : width of the shift/rotate frame counter for a given WIDTH
// ----------------------------------------------------------------------------
package storage_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROTL = 3'b100,
      MODE_ROTR = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_RSVD = 3'b111
   } mode_e;

   // Counter width: enough bits to hold WIDTH-1, never less than one bit.
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/universal_storage_register_frame_counter.sv
// ----------------------------------------------------------------------------
// frame_counter
// Counts shift/rotate operations and pulses frame_done on the edge that
// completes every WIDTH-th operation.
// Ports:
//   clk        in  : capture clock (edge already selected by the parent)
//   reset_n    in  : asynchronous active-low reset
//   count_en   in  : a shift/rotate is happening this edge
//   clear      in  : LOAD/CLR this edge; zeroes the count without a pulse
//   bit_cnt    out : operations counted in the current frame
//   frame_done out : registered one-edge completion pulse
// ----------------------------------------------------------------------------
module frame_counter
   import storage_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          count_en,
   input  logic                          clear,
   output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
   output logic                          frame_done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   // Next count and pulse; any non-counting edge drops the pulse.
   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (clear) begin
         cnt_d  = {CW{1'b0}};
         done_d = 1'b0;
      end else if (count_en) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = {CW{1'b0}};
            done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            done_d = 1'b0;
         end
      end else begin
         cnt_d  = cnt_q;
         done_d = 1'b0;
      end
   end

   // Counter and pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= {CW{1'b0}};
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign bit_cnt    = cnt_q;
   assign frame_done = done_q;

endmodule

// File: rtl/universal_storage_register.sv
// ----------------------------------------------------------------------------
// universal_storage_register
// WIDTH-bit universal register: hold / load / shift left / shift right /
// rotate left / rotate right / synchronous clear, with serial in/out on both
// ends and a frame counter over shift/rotate operations.
// Ports:
//   clk        in  : clock; capture edge chosen by EDGE (1 rising, 0 falling)
//   reset_n    in  : asynchronous active-low reset
//   en         in  : operation enable (0 holds q and the count)
//   mode       in  : operation select (storage_pkg::mode_e)
//   d          in  : parallel load data
//   sin_l      in  : serial in at LSB on shift-left
//   sin_r      in  : serial in at MSB on shift-right
//   q          out : register contents
//   sout_l     out : q[WIDTH-1]
//   sout_r     out : q[0]
//   bit_cnt    out : shift/rotate count in the current frame
//   frame_done out : one-edge pulse after each WIDTH-th shift/rotate
// ----------------------------------------------------------------------------
module universal_storage_register
   import storage_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter bit               EDGE      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic [2:0]                    mode,
   input  logic [WIDTH-1:0]              d,
   input  logic                          sin_l,
   input  logic                          sin_r,
   output logic [WIDTH-1:0]              q,
   output logic                          sout_l,
   output logic                          sout_r,
   output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
   output logic                          frame_done
);

   logic             cap_clk;
   logic [WIDTH-1:0] q_q, q_d;
   logic             count_en_s;
   logic             clear_s;

   // The only place the clock may be inverted: everything stateful runs on
   // cap_clk so both the register and the counter share the chosen edge.
   generate
      if (EDGE) begin : g_rise
         assign cap_clk = clk;
      end else begin : g_fall
         assign cap_clk = ~clk;
      end
   endgenerate

   // Next-state datapath and frame-counter controls from en/mode.
   always_comb begin
      q_d        = q_q;
      count_en_s = 1'b0;
      clear_s    = 1'b0;
      if (en) begin
         case (mode_e'(mode))
            MODE_HOLD: q_d = q_q;
            MODE_LOAD: begin
               q_d     = d;
               clear_s = 1'b1;
            end
            MODE_SHL: begin
               q_d        = {q_q[WIDTH-2:0], sin_l};
               count_en_s = 1'b1;
            end
            MODE_SHR: begin
               q_d        = {sin_r, q_q[WIDTH-1:1]};
               count_en_s = 1'b1;
            end
            MODE_ROTL: begin
               q_d        = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               count_en_s = 1'b1;
            end
            MODE_ROTR: begin
               q_d        = {q_q[0], q_q[WIDTH-1:1]};
               count_en_s = 1'b1;
            end
            MODE_CLR: begin
               q_d     = {WIDTH{1'b0}};
               clear_s = 1'b1;
            end
            MODE_RSVD: q_d = q_q;
            default:   q_d = q_q;
         endcase
      end else begin
         q_d = q_q;
      end
   end

   // Storage register.
   always_ff @(posedge cap_clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   frame_counter #(
      .WIDTH (WIDTH)
   ) u_frame_counter (
      .clk        (cap_clk),
      .reset_n    (reset_n),
      .count_en   (count_en_s),
      .clear      (clear_s),
      .bit_cnt    (bit_cnt),
      .frame_done (frame_done)
   );

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];

endmodule

// File: tb/tb_universal_storage_register.sv
// ----------------------------------------------------------------------------
// tb_universal_storage_register
// Directed bench: an 8-bit rising-edge instance for the functional sequence,
// plus a 4-bit rising/falling pair loaded together to show edge selection.
// ----------------------------------------------------------------------------
module tb_universal_storage_register;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_l, sin_r;
   logic [7:0] q;
   logic       sout_l, sout_r;
   logic [2:0] bit_cnt;
   logic       frame_done;

   logic       en4;
   logic [2:0] mode4;
   logic [3:0] d4;
   logic [3:0] qp, qn;
   logic       soutl_p, soutr_p, soutl_n, soutr_n;
   logic [1:0] cnt_p, cnt_n;
   logic       fd_p, fd_n;

   int cmps = 0;
   int errs = 0;

   universal_storage_register #(.WIDTH(8), .EDGE(1'b1), .RESET_VAL(8'h00)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d),
      .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l), .sout_r(sout_r),
      .bit_cnt(bit_cnt), .frame_done(frame_done));

   universal_storage_register #(.WIDTH(4), .EDGE(1'b1), .RESET_VAL(4'h0)) dut_pos (
      .clk(clk), .reset_n(reset_n), .en(en4), .mode(mode4), .d(d4),
      .sin_l(1'b0), .sin_r(1'b0), .q(qp), .sout_l(soutl_p), .sout_r(soutr_p),
      .bit_cnt(cnt_p), .frame_done(fd_p));

   universal_storage_register #(.WIDTH(4), .EDGE(1'b0), .RESET_VAL(4'h0)) dut_neg (
      .clk(clk), .reset_n(reset_n), .en(en4), .mode(mode4), .d(d4),
      .sin_l(1'b0), .sin_r(1'b0), .q(qn), .sout_l(soutl_n), .sout_r(soutr_n),
      .bit_cnt(cnt_n), .frame_done(fd_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one operation on the 8-bit instance and settle after the rising edge.
   task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dv,
                     input logic sl, input logic sr);
      en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q;

   initial begin
      reset_n = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
      en4 = 1'b0; mode4 = 3'b000; d4 = 4'h0;
      #1;
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_cnt", 32'(bit_cnt), 32'h0);
      chk("rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-operation
      op(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
      chk("load_a5", 32'(q), 32'hA5);
      op(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_cnt", 32'(bit_cnt), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_q", 32'(q), 32'h00);
      chk("async_rst_cnt", 32'(bit_cnt), 32'h0);
      chk("async_rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Load then SHL with sin_l = 1
      op(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
      chk("load_81", 32'(q), 32'h81);
      chk("load_81_soutl", 32'(sout_l), 32'h1);
      chk("load_81_soutr", 32'(sout_r), 32'h1);
      op(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      chk("shl1", 32'(q), 32'h03);
      chk("shl1_soutl", 32'(sout_l), 32'h0);
      op(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      chk("shl2", 32'(q), 32'h07);
      op(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      chk("shl3", 32'(q), 32'h0F);
      chk("shl3_soutl", 32'(sout_l), 32'h0);
      chk("shl3_cnt", 32'(bit_cnt), 32'h3);

      // SHR with sin_r = 0
      op(1'b1, 3'b001, 8'hF0, 1'b0, 1'b0);
      chk("load_f0_cnt", 32'(bit_cnt), 32'h0);
      op(1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
      chk("shr1", 32'(q), 32'h78);
      chk("shr1_soutr", 32'(sout_r), 32'h0);
      op(1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
      chk("shr2", 32'(q), 32'h3C);
      chk("shr2_soutr", 32'(sout_r), 32'h0);
      chk("shr2_cnt", 32'(bit_cnt), 32'h2);

      // ROTL 8 edges from 01, then a ninth
      op(1'b1, 3'b001, 8'h01, 1'b0, 1'b0);
      exp_q = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
         exp_q = {exp_q[6:0], exp_q[7]};
         chk($sformatf("rotl%0d_q", i), 32'(q), 32'(exp_q));
         chk($sformatf("rotl%0d_fd", i), 32'(frame_done), (i == 8) ? 32'h1 : 32'h0);
         chk($sformatf("rotl%0d_cnt", i), 32'(bit_cnt), 32'(i % 8));
      end
      op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      chk("rotl9_q", 32'(q), 32'h02);
      chk("rotl9_fd", 32'(frame_done), 32'h0);

      // Interrupted frame: 5 ROTR, hold 2 edges, CLR
      op(1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      chk("rotr5_q", 32'(q), 32'hE1);
      chk("rotr5_cnt", 32'(bit_cnt), 32'h5);
      op(1'b0, 3'b010, 8'h00, 1'b1, 1'b1);
      op(1'b0, 3'b001, 8'hFF, 1'b1, 1'b1);
      chk("hold_q", 32'(q), 32'hE1);
      chk("hold_cnt", 32'(bit_cnt), 32'h5);
      op(1'b1, 3'b110, 8'hFF, 1'b0, 1'b0);
      chk("clr_q", 32'(q), 32'h00);
      chk("clr_cnt", 32'(bit_cnt), 32'h0);
      chk("clr_fd", 32'(frame_done), 32'h0);

      // LOAD at bit_cnt = WIDTH-1: no pulse
      op(1'b1, 3'b001, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      chk("rotl7_cnt", 32'(bit_cnt), 32'h7);
      op(1'b1, 3'b001, 8'hAA, 1'b0, 1'b0);
      chk("load_last_q", 32'(q), 32'hAA);
      chk("load_last_cnt", 32'(bit_cnt), 32'h0);
      chk("load_last_fd", 32'(frame_done), 32'h0);

      // Mixed-direction full frame, then pulse drops after en=0
      for (int i = 0; i < 4; i++) op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
      chk("mixed_q", 32'(q), 32'hAA);
      chk("mixed_fd", 32'(frame_done), 32'h1);
      op(1'b0, 3'b100, 8'h00, 1'b0, 1'b0);
      chk("fd_drop", 32'(frame_done), 32'h0);

      // Reserved mode with en = 1
      op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      op(1'b1, 3'b111, 8'h55, 1'b1, 1'b1);
      chk("rsvd_q", 32'(q), 32'h55);
      chk("rsvd_cnt", 32'(bit_cnt), 32'h1);
      chk("rsvd_fd", 32'(frame_done), 32'h0);

      // Edge selection: load 4'h9 into both 4-bit instances mid-cycle
      en4 = 1'b1; mode4 = 3'b001; d4 = 4'h9;
      @(negedge clk);
      #1;
      chk("neg_first_qn", 32'(qn), 32'h9);
      chk("neg_first_qp", 32'(qp), 32'h0);
      @(posedge clk);
      #1;
      chk("pos_later_qp", 32'(qp), 32'h9);
      en4 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
